label_merge_ctrl: RTL and testbench

LABEL_MERGE_CTRL -- requirements
Module: label_merge_ctrl

---
 rtl/label_merge_ctrl_pkg.sv | 9 +
 rtl/label_merge_ctrl_fifo.sv | 35 +++
 rtl/label_merge_ctrl.sv | 98 +++++++++
 tb/tb_label_merge_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/label_merge_ctrl_pkg.sv
// label_merge_ctrl_pkg: shared label width default, FSM state encoding and merge request type
package label_merge_ctrl_pkg;
  localparam int LABEL_WIDTH_DEF = 8;
  typedef enum logic [2:0] {IDLE, FIND_A, FIND_B, UNION, FLATTEN, DONE} state_t;
  typedef struct packed {
    logic [LABEL_WIDTH_DEF-1:0] a;
    logic [LABEL_WIDTH_DEF-1:0] b;
  } merge_req_t;
endpackage

// File: rtl/label_merge_ctrl_fifo.sv
// merge_fifo: synchronous request queue (clk, rst, push/din, pop/dout, full, empty), show-ahead read
module merge_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/label_merge_ctrl.sv
// label_merge_ctrl: union-find label merge table (new labels, queued merges, frame_end flatten, rd_label->rd_root lookup, ready/busy/done/overflow status)
module label_merge_ctrl
  import label_merge_ctrl_pkg::*;
#(
  parameter int LABEL_WIDTH = LABEL_WIDTH_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_label_valid,
  input  logic [LABEL_WIDTH-1:0] new_label_value,
  input  logic                   merge_valid,
  input  logic [LABEL_WIDTH-1:0] merge_a,
  input  logic [LABEL_WIDTH-1:0] merge_b,
  input  logic                   frame_end,
  output logic                   merge_ready,
  output logic                   resolve_busy,
  output logic                   resolve_done,
  input  logic [LABEL_WIDTH-1:0] rd_label,
  output logic [LABEL_WIDTH-1:0] rd_root,
  output logic                   overflow
);
  localparam int W = LABEL_WIDTH;
  localparam int N = 1 << W;
  logic [W-1:0] parent [N];
  state_t state;
  logic [W-1:0] ra, rb, idx, max_label;
  logic pending, full, empty, push, pop, trivial, lbl_wr, un_wr;
  logic [2*W-1:0] q_dout;
  merge_fifo #(.WIDTH(2*W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din({merge_a, merge_b}),
    .dout(q_dout), .full(full), .empty(empty)
  );
  assign resolve_busy = pending;
  assign resolve_done = state == DONE;
  assign pop = state == IDLE && !empty;
  // a pop in the same cycle frees a slot, so a full queue can still accept
  assign merge_ready = (!full || pop) && !pending;
  assign trivial = merge_a == '0 || merge_b == '0 || merge_a == merge_b;
  assign push = merge_valid && merge_ready && !trivial;
  assign lbl_wr = new_label_valid && new_label_value != '0 && !pending;
  assign un_wr = state == UNION && ra != rb;
  assign rd_root = parent[rd_label];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      idx <= '0;
      max_label <= '0;
      pending <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < N; i++) parent[i] <= W'(i);
    end else begin
      if ((merge_valid && !merge_ready) || (new_label_valid && pending)) overflow <= 1'b1;
      if (frame_end) pending <= 1'b1;
      if (lbl_wr) begin
        parent[new_label_value] <= new_label_value;
        if (new_label_value > max_label) max_label <= new_label_value;
      end
      case (state)
        IDLE:
          if (!empty) begin
            ra <= q_dout[2*W-1:W];
            rb <= q_dout[W-1:0];
            state <= FIND_A;
          end else if (pending) begin
            idx <= W'(1);
            state <= FLATTEN;
          end
        FIND_A:
          if (parent[ra] == ra) state <= FIND_B;
          else ra <= parent[ra];
        FIND_B:
          if (parent[rb] == rb) state <= UNION;
          else rb <= parent[rb];
        UNION:
          // the label write owns the table this cycle; retry the union next cycle
          if (!(un_wr && lbl_wr)) begin
            if (un_wr) parent[ra > rb ? ra : rb] <= ra > rb ? rb : ra;
            state <= IDLE;
          end
        FLATTEN: begin
          // ascending order guarantees parent[parent[idx]] is already a root
          parent[idx] <= parent[parent[idx]];
          idx <= idx + 1'b1;
          if (idx >= max_label) state <= DONE;
        end
        DONE: begin
          pending <= 1'b0;
          max_label <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_label_merge_ctrl.sv
// tb_label_merge_ctrl: directed self-checking bench for label_merge_ctrl
module tb_label_merge_ctrl;
  logic clk = 1'b0;
  logic rst, new_label_valid, merge_valid, frame_end;
  logic [7:0] new_label_value, merge_a, merge_b, rd_label, rd_root;
  logic merge_ready, resolve_busy, resolve_done, overflow;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  label_merge_ctrl dut (
    .clk(clk), .rst(rst), .new_label_valid(new_label_valid), .new_label_value(new_label_value),
    .merge_valid(merge_valid), .merge_a(merge_a), .merge_b(merge_b), .frame_end(frame_end),
    .merge_ready(merge_ready), .resolve_busy(resolve_busy), .resolve_done(resolve_done),
    .rd_label(rd_label), .rd_root(rd_root), .overflow(overflow)
  );
  task tick;
    @(posedge clk);
    #1;
  endtask
  task do_reset;
    rst = 1'b1;
    new_label_valid = 1'b0;
    new_label_value = '0;
    merge_valid = 1'b0;
    merge_a = '0;
    merge_b = '0;
    frame_end = 1'b0;
    rd_label = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task new_lbl(input logic [7:0] v);
    new_label_valid = 1'b1;
    new_label_value = v;
    tick;
    new_label_valid = 1'b0;
  endtask
  task lookup(input logic [7:0] l, output logic [7:0] r);
    rd_label = l;
    #1;
    r = rd_root;
  endtask
  task do_merge(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!merge_ready && n < 100) begin
      tick;
      n++;
    end
    checks++;
    if (merge_ready !== 1'b1) begin
      failures++;
      $display("FAIL merge_ready_wait got=%b exp=1", merge_ready);
    end
    merge_valid = 1'b1;
    merge_a = a;
    merge_b = b;
    tick;
    merge_valid = 1'b0;
  endtask
  task pulse_frame_end;
    frame_end = 1'b1;
    tick;
    frame_end = 1'b0;
  endtask
  task wait_done(output int cyc);
    cyc = 0;
    while (!resolve_done && cyc < 300) begin
      tick;
      cyc++;
    end
  endtask
  task test_reset;
    logic [7:0] r;
    logic [7:0] ids [5] = '{8'd0, 8'd1, 8'd2, 8'd200, 8'd255};
    do_reset;
    checks++;
    if ({merge_ready, resolve_busy, resolve_done, overflow} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1000", {merge_ready, resolve_busy, resolve_done, overflow});
    end
    foreach (ids[i]) begin
      lookup(ids[i], r);
      checks++;
      if (r !== ids[i]) begin
        failures++;
        $display("FAIL reset_identity label=%0d got=%0d exp=%0d", ids[i], r, ids[i]);
      end
    end
  endtask
  task test_basic;
    logic [7:0] r;
    int cyc;
    do_reset;
    for (int i = 1; i <= 3; i++) new_lbl(8'(i));
    do_merge(8'd1, 8'd2);
    do_merge(8'd2, 8'd3);
    repeat (20) tick;
    pulse_frame_end;
    checks++;
    if ({resolve_busy, merge_ready} !== 2'b10) begin
      failures++;
      $display("FAIL basic_busy busy_ready got=%b exp=10", {resolve_busy, merge_ready});
    end
    wait_done(cyc);
    checks++;
    if (resolve_done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done got=%b exp=1", resolve_done);
    end
    tick;
    checks++;
    if ({resolve_done, resolve_busy} !== 2'b00) begin
      failures++;
      $display("FAIL basic_after_done done_busy got=%b exp=00", {resolve_done, resolve_busy});
    end
    lookup(8'd3, r);
    checks++;
    if (r !== 8'd1) begin
      failures++;
      $display("FAIL basic_root3 got=%0d exp=1", r);
    end
    lookup(8'd2, r);
    checks++;
    if (r !== 8'd1) begin
      failures++;
      $display("FAIL basic_root2 got=%0d exp=1", r);
    end
  endtask
  task test_chain;
    logic [7:0] r;
    int cyc;
    do_reset;
    for (int i = 1; i <= 5; i++) new_lbl(8'(i));
    for (int k = 4; k >= 1; k--) do_merge(8'(k), 8'(k + 1));
    repeat (30) tick;
    lookup(8'd5, r);
    checks++;
    if (r !== 8'd4) begin
      failures++;
      $display("FAIL chain_prefl_root5 got=%0d exp=4", r);
    end
    pulse_frame_end;
    wait_done(cyc);
    // one IDLE cycle to leave for FLATTEN, then five FLATTEN cycles for labels 1..5
    checks++;
    if (cyc !== 6 || resolve_done !== 1'b1) begin
      failures++;
      $display("FAIL chain_flatten_cycles got=%0d done=%b exp=6 done=1", cyc, resolve_done);
    end
    tick;
    for (int i = 1; i <= 5; i++) begin
      lookup(8'(i), r);
      checks++;
      if (r !== 8'd1) begin
        failures++;
        $display("FAIL chain_root label=%0d got=%0d exp=1", i, r);
      end
    end
  endtask
  task test_overflow_stall;
    logic [7:0] r;
    do_reset;
    for (int i = 1; i <= 16; i++) new_lbl(8'(i));
    for (int k = 15; k >= 1; k--) do_merge(8'(k), 8'(k + 1));
    repeat (120) tick;
    lookup(8'd16, r);
    checks++;
    if (r !== 8'd15) begin
      failures++;
      $display("FAIL stall_chain_root16 got=%0d exp=15", r);
    end
    // the deep find on label 16 keeps the FSM out of IDLE while the queue fills
    merge_valid = 1'b1;
    merge_a = 8'd16;
    merge_b = 8'd1;
    tick;
    merge_a = 8'd1;
    merge_b = 8'd2;
    repeat (8) tick;
    checks++;
    if ({overflow, merge_ready} !== 2'b00) begin
      failures++;
      $display("FAIL stall_full_8 ovf_ready got=%b exp=00", {overflow, merge_ready});
    end
    tick;
    merge_valid = 1'b0;
    checks++;
    if ({overflow, merge_ready} !== 2'b10) begin
      failures++;
      $display("FAIL stall_drop_9 ovf_ready got=%b exp=10", {overflow, merge_ready});
    end
    repeat (150) tick;
    checks++;
    if ({overflow, merge_ready} !== 2'b11) begin
      failures++;
      $display("FAIL stall_drained ovf_ready got=%b exp=11", {overflow, merge_ready});
    end
  endtask
  task test_trivial;
    logic [7:0] r;
    do_reset;
    for (int i = 1; i <= 3; i++) new_lbl(8'(i));
    do_merge(8'd0, 8'd3);
    do_merge(8'd2, 8'd2);
    do_merge(8'd3, 8'd0);
    repeat (15) tick;
    checks++;
    if ({merge_ready, overflow} !== 2'b10) begin
      failures++;
      $display("FAIL trivial_flags ready_ovf got=%b exp=10", {merge_ready, overflow});
    end
    lookup(8'd3, r);
    checks++;
    if (r !== 8'd3) begin
      failures++;
      $display("FAIL trivial_root3 got=%0d exp=3", r);
    end
    lookup(8'd2, r);
    checks++;
    if (r !== 8'd2) begin
      failures++;
      $display("FAIL trivial_root2 got=%0d exp=2", r);
    end
  endtask
  task test_collision;
    logic [7:0] r;
    do_reset;
    for (int i = 1; i <= 5; i++) new_lbl(8'(i));
    do_merge(8'd1, 8'd2);
    repeat (3) tick;
    lookup(8'd2, r);
    checks++;
    if (r !== 8'd2) begin
      failures++;
      $display("FAIL latency_early got=%0d exp=2", r);
    end
    tick;
    lookup(8'd2, r);
    checks++;
    if (r !== 8'd1) begin
      failures++;
      $display("FAIL latency_write got=%0d exp=1", r);
    end
    tick;
    do_merge(8'd3, 8'd5);
    repeat (3) tick;
    new_label_valid = 1'b1;
    new_label_value = 8'd7;
    tick;
    new_label_valid = 1'b0;
    lookup(8'd7, r);
    checks++;
    if (r !== 8'd7) begin
      failures++;
      $display("FAIL collide_new7 got=%0d exp=7", r);
    end
    lookup(8'd5, r);
    checks++;
    if (r !== 8'd5) begin
      failures++;
      $display("FAIL collide_stalled5 got=%0d exp=5", r);
    end
    tick;
    lookup(8'd5, r);
    checks++;
    if (r !== 8'd3) begin
      failures++;
      $display("FAIL collide_late5 got=%0d exp=3", r);
    end
  endtask
  task test_busy_label;
    int cyc;
    do_reset;
    new_lbl(8'd1);
    pulse_frame_end;
    new_lbl(8'd9);
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL busy_label_ovf got=%b exp=1", overflow);
    end
    wait_done(cyc);
    // max_label stays 1, so FLATTEN is a single cycle
    checks++;
    if (cyc !== 1 || resolve_done !== 1'b1) begin
      failures++;
      $display("FAIL busy_label_flatten got=%0d done=%b exp=1 done=1", cyc, resolve_done);
    end
    tick;
  endtask
  task test_rst_flatten;
    logic [7:0] r;
    int seen;
    do_reset;
    for (int i = 1; i <= 5; i++) new_lbl(8'(i));
    do_merge(8'd4, 8'd5);
    do_merge(8'd3, 8'd4);
    repeat (20) tick;
    pulse_frame_end;
    tick;
    tick;
    checks++;
    if ({resolve_busy, resolve_done} !== 2'b10) begin
      failures++;
      $display("FAIL rstfl_mid busy_done got=%b exp=10", {resolve_busy, resolve_done});
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({resolve_busy, merge_ready, resolve_done} !== 3'b010) begin
      failures++;
      $display("FAIL rstfl_flags busy_ready_done got=%b exp=010", {resolve_busy, merge_ready, resolve_done});
    end
    for (int i = 3; i <= 5; i++) begin
      lookup(8'(i), r);
      checks++;
      if (r !== 8'(i)) begin
        failures++;
        $display("FAIL rstfl_identity label=%0d got=%0d exp=%0d", i, r, i);
      end
    end
    seen = 0;
    repeat (20) begin
      tick;
      if (resolve_done) seen = 1;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rstfl_no_done got=%0d exp=0", seen);
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_chain;
    test_overflow_stall;
    test_trivial;
    test_collision;
    test_busy_label;
    test_rst_flatten;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
